seq_restoring_div: RTL and testbench

- Iterative unsigned restoring divider, one quotient bit per clock.
- Computes quotient = dividend / divisor and remainder = dividend mod divisor.
- Each iteration uses an (n+1)-bit ripple subtract, built from full adders with the divisor complemented.
- Sits beside the ripple adder/subtractor datapath as the multi-cycle inverse-arithmetic unit, with a start/busy/done handshake.

---
 rtl/div_pkg.sv | 17 +
 rtl/full_adder.sv | 20 ++
 rtl/sub_nbit.sv | 36 +++
 rtl/seq_restoring_div.sv | 184 ++++++++++++++++++
 tb/tb_seq_restoring_div.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   state_t : FSM state encoding (IDLE = 0, RUN = 1, DONE = 2)
//   DIV_N   : default operand / quotient / remainder width
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell used to build the ripple subtractor.
//   i_a, i_b  : addend bits
//   i_cin     : carry in
//   o_s       : sum bit
//   o_cout    : carry out
// ----------------------------------------------------------------------------
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/sub_nbit.sv
// ----------------------------------------------------------------------------
// sub_nbit
// W-bit unsigned ripple subtractor: o_diff = i_a - i_b.
// Built as a chain of full adders adding ~i_b with carry-in 1.
//   i_a, i_b  : W-bit unsigned operands
//   o_diff    : W-bit difference (modulo 2^W)
//   o_borrow  : 1 when i_a < i_b
// ----------------------------------------------------------------------------
module sub_nbit #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic         o_borrow
);

    logic [W:0] w_carry;

    // Two's-complement subtract: a + ~b + 1
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g < W; g++) begin : g_fa
        full_adder u_fa (
            .i_a    (i_a[g]),
            .i_b    (~i_b[g]),
            .i_cin  (w_carry[g]),
            .o_s    (o_diff[g]),
            .o_cout (w_carry[g+1])
        );
    end

    // No carry out of the top cell means the result went negative
    assign o_borrow = ~w_carry[W];

endmodule

// File: rtl/seq_restoring_div.sv
// ----------------------------------------------------------------------------
// seq_restoring_div
// Iterative unsigned restoring divider producing one quotient bit per clock.
// A result appears n+1 cycles after the cycle in which start is accepted.
//
// Ports:
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset (aborts any operation)
//   start        : request, sampled in IDLE and DONE only
//   dividend     : n-bit unsigned dividend, captured on accepted start
//   divisor      : n-bit unsigned divisor, captured on accepted start
//   busy         : high while iterating
//   done         : one-cycle pulse, results valid from this cycle
//   quotient     : n-bit quotient, held until the next done
//   remainder    : n-bit remainder, held until the next done
//   div_by_zero  : set with done when the captured divisor was zero
//
// Configuration macro:
//   DIV_DBZ_FAST_EN : when defined, a zero divisor skips the iterations and
//                     completes in the cycle right after acceptance.
// ----------------------------------------------------------------------------
module seq_restoring_div
    import div_pkg::*;
#(
    parameter int n = DIV_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);

    localparam int            CW       = $clog2(n + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(n);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        r_state;
    state_t        w_state_nxt;

    logic [n-1:0]  r_q;
    logic [n-1:0]  r_r;
    logic [n-1:0]  r_d;
    logic [CW-1:0] r_cnt;
    logic          r_dbz_cap;
    logic [n-1:0]  r_quot;
    logic [n-1:0]  r_rem;
    logic          r_dbz;

    logic          w_accept;
    logic          w_busy;
    logic          w_done;
    logic          w_last;
`ifdef DIV_DBZ_FAST_EN
    logic          w_fast;
`endif

    logic [n:0]    w_rshift;
    logic [n:0]    w_trial;
    logic          w_borrow;
    logic          w_unused_trial_msb;
    logic [n-1:0]  w_q_nxt;
    logic [n-1:0]  w_r_nxt;

    // Shift {R,Q} left: the partial remainder gains the next dividend bit
    assign w_rshift = {r_r, r_q[n-1]};

    sub_nbit #(
        .W (n + 1)
    ) u_sub (
        .i_a      (w_rshift),
        .i_b      ({1'b0, r_d}),
        .o_diff   (w_trial),
        .o_borrow (w_borrow)
    );

    // Without a borrow the trial difference is below the divisor, so its
    // top bit is always zero and only the low n bits are kept.
    assign w_unused_trial_msb = w_trial[n];

    // Restore on borrow, otherwise keep the difference
    assign w_r_nxt = w_borrow ? w_rshift[n-1:0] : w_trial[n-1:0];
    assign w_q_nxt = {r_q[n-2:0], ~w_borrow};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_last      = 1'b0;
`ifdef DIV_DBZ_FAST_EN
        w_fast      = 1'b0;
`endif
        case (r_state)
            IDLE, DONE: begin
                // DONE accepts a new start exactly like IDLE
                w_done      = (r_state == DONE);
                w_state_nxt = IDLE;
                if (start) begin
                    w_accept    = 1'b1;
`ifdef DIV_DBZ_FAST_EN
                    if (divisor == '0) begin
                        w_fast      = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
`else
                    w_state_nxt = RUN;
`endif
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_ONE) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_r       <= '0;
            r_d       <= '0;
            r_cnt     <= '0;
            r_dbz_cap <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dbz     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_q       <= dividend;
                r_d       <= divisor;
                r_r       <= '0;
                r_cnt     <= CNT_INIT;
                r_dbz_cap <= (divisor == '0);
            end else if (w_busy) begin
                r_q   <= w_q_nxt;
                r_r   <= w_r_nxt;
                r_cnt <= r_cnt - CNT_ONE;
            end

            // Result registers only move when entering DONE
            if (w_last) begin
                r_quot <= w_q_nxt;
                r_rem  <= w_r_nxt;
                r_dbz  <= r_dbz_cap;
            end
`ifdef DIV_DBZ_FAST_EN
            if (w_fast) begin
                r_quot <= '1;
                r_rem  <= dividend;
                r_dbz  <= 1'b1;
            end
`endif
        end
    end

    assign busy        = w_busy;
    assign done        = w_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_div.sv
// ----------------------------------------------------------------------------
// tb_seq_restoring_div
// Scoreboard bench for seq_restoring_div (n = 8). Stimulus pushes the
// hand-computed result and the cycle it must appear in; a negedge monitor
// pops and compares on every done pulse.
// ----------------------------------------------------------------------------
module tb_seq_restoring_div;

    localparam int N = 8;
`ifdef DIV_DBZ_FAST_EN
    localparam int DBZ_LAT = 1;
`else
    localparam int DBZ_LAT = N + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        int q;
        int r;
        int z;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    seq_restoring_div #(.n(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quotient",    int'(quotient),    e.q);
                check("remainder",   int'(remainder),   e.r);
                check("div_by_zero", int'(div_by_zero), e.z);
                check("done_cycle",  cyc,               e.cyc);
            end
        end
    end

    // Called just after a posedge; holds start for one cycle
    task automatic issue(input int a, input int b, input int q, input int r,
                         input int z, output int s);
        exp_t e;
        dividend = N'(a);
        divisor  = N'(b);
        start    = 1'b1;
        s        = cyc;
        e.q = q;
        e.r = r;
        e.z = z;
        e.cyc = s + ((b == 0) ? DBZ_LAT : N + 1);
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int s;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quot", int'(quotient), 0);
        check("rst_rem",  int'(remainder), 0);
        check("rst_dbz",  int'(div_by_zero), 0);

        // 100 / 7 with busy window checks
        issue(100, 7, 14, 2, 0, s);
        check("busy_first", int'(busy), 1);
        repeat (7) begin @(posedge clk); #1; end
        check("busy_last", int'(busy), 1);
        @(posedge clk); #1;
        check("busy_after", int'(busy), 0);
        drain();

        issue(255, 1, 255, 0, 0, s);
        drain();
        issue(5, 200, 0, 5, 0, s);
        drain();
        issue(77, 0, 255, 77, 1, s);
        drain();

        // Start during RUN is ignored; outputs keep the previous result
        issue(50, 3, 16, 2, 0, s);
        repeat (2) begin @(posedge clk); #1; end
        dividend = 8'd9;
        divisor  = 8'd9;
        start    = 1'b1;
        check("hold_busy", int'(busy), 1);
        check("hold_quot", int'(quotient), 255);
        check("hold_rem",  int'(remainder), 77);
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h00;
        check("hold_quot2", int'(quotient), 255);
        drain();

        // Back-to-back: start during the done cycle
        issue(60, 6, 10, 0, 0, s);
        while (cyc < s + N + 1) begin @(posedge clk); #1; end
        check("b2b_done_seen", int'(done), 1);
        issue(200, 16, 12, 8, 0, s);
        drain();

        // Reset at RUN iteration 4 aborts without a done
        issue(100, 7, 14, 2, 0, s);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_quot", int'(quotient), 0);
        check("abort_rem",  int'(remainder), 0);
        check("abort_dbz",  int'(div_by_zero), 0);
        repeat (12) begin @(posedge clk); #1; end
        issue(9, 3, 3, 0, 0, s);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
